bist_pattern_gen16: RTL and testbench

BIST_PATTERN_GEN16 -- requirements
Module: bist_pattern_gen16

---
 rtl/bist_pattern_gen16.sv | 103 ++++++++++
 tb/tb_bist_pattern_gen16.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bist_pattern_gen16.sv
// BIST pattern generator: emits a run of patterns from a 16-bit Galois LFSR.
// The run is seeded and counted on start, can be stalled by hold, and ends with a one-cycle done pulse.
module bist_pattern_gen16 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      seed,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic             hold,
    output logic [15:0]      pattern,
    output logic             pattern_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    // Same feedback taps (x^16+x^12+x^3+x+1) as the 16-bit signature analyzer.
    function automatic logic [15:0] lfsr_next(input logic [15:0] p);
        return {p[14:0], 1'b0} ^ ({16{p[15]}} & 16'h100B);
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [15:0]      pattern_r;
    logic [15:0]      pattern_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             pattern_valid_r;
    logic             busy_r;
    logic             done_r;

    // Next-state, next-pattern and next-count selection.
    always_comb begin
        state_nxt_s   = state_r;
        pattern_nxt_s = pattern_r;
        cnt_nxt_s     = cnt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (num_patterns != {CNT_W{1'b0}}) begin
                        state_nxt_s   = RUN;
                        cnt_nxt_s     = num_patterns;
                        // An all-zero seed would lock the LFSR.
                        pattern_nxt_s = (seed == 16'h0000) ? 16'hFFFF : seed;
                    end else begin
                        state_nxt_s = FIN;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (!hold) begin
                    if (cnt_r == CNT_W'(1)) begin
                        state_nxt_s = FIN;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_nxt_s     = cnt_r - CNT_W'(1);
                        pattern_nxt_s = lfsr_next(pattern_r);
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FIN: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, pattern, counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            pattern_r       <= 16'hFFFF;
            cnt_r           <= {CNT_W{1'b0}};
            pattern_valid_r <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            pattern_r       <= pattern_nxt_s;
            cnt_r           <= cnt_nxt_s;
            pattern_valid_r <= (state_nxt_s == RUN);
            busy_r          <= (state_nxt_s == RUN);
            done_r          <= (state_nxt_s == FIN);
        end
    end

    assign pattern       = pattern_r;
    assign pattern_valid = pattern_valid_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_bist_pattern_gen16.sv
// Directed self-checking bench for bist_pattern_gen16 with hand-computed LFSR values.
module tb_bist_pattern_gen16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic [15:0] num_patterns = 16'h0000;
    logic        hold = 1'b0;
    logic [15:0] pattern;
    logic        pattern_valid;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    bist_pattern_gen16 #(.CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .seed          (seed),
        .num_patterns  (num_patterns),
        .hold          (hold),
        .pattern       (pattern),
        .pattern_valid (pattern_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks pattern, pattern_valid, busy and done together.
    task automatic chk_all(input string tag, input logic [15:0] p, input logic pv,
                           input logic b, input logic d);
        chk({tag, ".pattern"}, pattern, p);
        chk({tag, ".valid"}, {15'd0, pattern_valid}, {15'd0, pv});
        chk({tag, ".busy"}, {15'd0, busy}, {15'd0, b});
        chk({tag, ".done"}, {15'd0, done}, {15'd0, d});
    endtask

    initial begin
        // Reset, then idle
        reset = 1'b1;
        tick();
        chk_all("reset", 16'hFFFF, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("idle", 16'hFFFF, 1'b0, 1'b0, 1'b0);
        end

        // seed 0001, 3 patterns
        seed = 16'h0001; num_patterns = 16'd3; start = 1'b1;
        tick();
        chk_all("run3.p1", 16'h0001, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        chk_all("run3.p2", 16'h0002, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("run3.p3", 16'h0004, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("run3.fin", 16'h0004, 1'b0, 1'b0, 1'b1);
        tick();
        chk_all("run3.idle", 16'h0004, 1'b0, 1'b0, 1'b0);

        // seed 8000, 2 patterns; start held and seed changed during RUN
        seed = 16'h8000; num_patterns = 16'd2; start = 1'b1;
        tick();
        chk_all("s8000.p1", 16'h8000, 1'b1, 1'b1, 1'b0);
        seed = 16'h1234; num_patterns = 16'd7;
        tick();
        chk_all("s8000.p2", 16'h100B, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("s8000.fin", 16'h100B, 1'b0, 1'b0, 1'b1);
        // start during FIN is ignored; then accepted back-to-back from IDLE
        seed = 16'h0000; num_patterns = 16'd2; start = 1'b1;
        tick();
        chk_all("fin_start_ignored", 16'h100B, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("s0000.p1", 16'hFFFF, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        chk_all("s0000.p2", 16'hEFF5, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("s0000.fin", 16'hEFF5, 1'b0, 1'b0, 1'b1);

        // Zero-length run
        tick();
        seed = 16'h5555; num_patterns = 16'd0; start = 1'b1;
        tick();
        chk_all("zero.fin", 16'hEFF5, 1'b0, 1'b0, 1'b1);
        start = 1'b0;
        tick();
        chk_all("zero.idle", 16'hEFF5, 1'b0, 1'b0, 1'b0);

        // Hold during cycles T+2..T+3
        seed = 16'h0001; num_patterns = 16'd3; start = 1'b1;
        tick();
        chk_all("hold.t1", 16'h0001, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        chk_all("hold.t2", 16'h0002, 1'b1, 1'b1, 1'b0);
        hold = 1'b1;
        tick();
        chk_all("hold.t3", 16'h0002, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("hold.t4", 16'h0002, 1'b1, 1'b1, 1'b0);
        hold = 1'b0;
        tick();
        chk_all("hold.t5", 16'h0004, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("hold.t6", 16'h0004, 1'b0, 1'b0, 1'b1);
        // hold in FIN has no effect
        hold = 1'b1;
        tick();
        chk_all("hold.fin_exit", 16'h0004, 1'b0, 1'b0, 1'b0);
        hold = 1'b0;

        // Reset aborts a 5-pattern run after its second pattern
        seed = 16'h8000; num_patterns = 16'd5; start = 1'b1;
        tick();
        chk_all("abort.p1", 16'h8000, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        chk_all("abort.p2", 16'h100B, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        chk_all("abort.reset", 16'hFFFF, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("abort.no_done", 16'hFFFF, 1'b0, 1'b0, 1'b0);
        end
        seed = 16'h8000; num_patterns = 16'd1; start = 1'b1;
        tick();
        chk_all("restart.p1", 16'h8000, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        chk_all("restart.fin", 16'h8000, 1'b0, 1'b0, 1'b1);
        tick();

        // Reset wins over start and hold
        seed = 16'h0001; num_patterns = 16'd3; start = 1'b1; hold = 1'b1; reset = 1'b1;
        tick();
        chk_all("reset_prio", 16'hFFFF, 1'b0, 1'b0, 1'b0);
        reset = 1'b0; start = 1'b0; hold = 1'b0;
        tick();
        chk_all("reset_prio.idle", 16'hFFFF, 1'b0, 1'b0, 1'b0);

        // Reset in FIN: no further done
        seed = 16'h0001; num_patterns = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_all("finrst.fin", 16'h0001, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        chk_all("finrst.reset", 16'hFFFF, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk_all("finrst.idle", 16'hFFFF, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
